// File: rtl/mini_alu_ram_arbiter.sv
// rtl/mini_alu_ram_arbiter.sv - MiniAlu data RAM write-port arbiter (ALU priority, loader starvation guard; optional bursts via MINI_ALU_ARB_BURST_EN)
//
// The ALU writeback path owns the RAM write port by default. An external
// loader (valid/ready) gets the port whenever the ALU is idle. If the loader
// keeps being denied, the port is handed to it for one cycle (or for a
// whole burst when MINI_ALU_ARB_BURST_EN is defined) and the ALU is stalled.
// All RAM write outputs are registered, so a write granted in cycle N shows
// up on the outputs in cycle N+1 for either requester.

module mini_alu_ram_arbiter #(
    parameter int DATA_WIDTH   = 16,
    parameter int ADDR_WIDTH   = 8,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  iAluWriteEnable,
    input  logic [ADDR_WIDTH-1:0] iAluAddress,
    input  logic [DATA_WIDTH-1:0] iAluData,
    output logic                  oAluStall,
    input  logic                  iLdValid,
    input  logic [ADDR_WIDTH-1:0] iLdAddress,
    input  logic [DATA_WIDTH-1:0] iLdData,
    input  logic                  iLdLast,
    output logic                  oLdReady,
    output logic                  oWriteEnable,
    output logic [ADDR_WIDTH-1:0] oWriteAddress,
    output logic [DATA_WIDTH-1:0] oDataIn
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT    = CNT_W'(STARVE_LIMIT);
    localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(STARVE_LIMIT - 1);

    typedef enum logic {
        S_ALU   = 1'b0,
        S_FORCE = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] starve_cnt;
    logic             ld_xfer;
    logic             alu_grant;
    logic             ld_denied;
    logic             ends_ownership;

`ifndef MINI_ALU_ARB_BURST_EN
    // Single-word ownership: the last-word flag carries no meaning here.
    logic unused_ld_last;
    assign unused_ld_last = iLdLast;
`endif

    // Handshake outputs, grant decode and next-state selection.
    always_comb begin
        state_next     = state;
        oLdReady       = 1'b0;
        oAluStall      = 1'b0;
        ld_xfer        = 1'b0;
        alu_grant      = 1'b0;
        ld_denied      = 1'b0;
        ends_ownership = 1'b0;

        case (state)
            S_ALU: begin
                oLdReady = iLdValid & ~iAluWriteEnable;
            end
            S_FORCE: begin
                oLdReady  = iLdValid;
                oAluStall = iAluWriteEnable;
            end
            default: begin
                oLdReady = 1'b0;
            end
        endcase

        // Nobody may believe a transfer or a stall happened while in reset.
        if (Reset) begin
            oLdReady  = 1'b0;
            oAluStall = 1'b0;
        end

        ld_xfer   = iLdValid & oLdReady;
        alu_grant = iAluWriteEnable & ~oAluStall;
        ld_denied = (state == S_ALU) & iLdValid & iAluWriteEnable;

`ifdef MINI_ALU_ARB_BURST_EN
        ends_ownership = ld_xfer & iLdLast;
`else
        ends_ownership = ld_xfer;
`endif

        case (state)
            S_ALU: begin
                // The denial that brings the counter to its limit hands the
                // port over, so the loader is served on the very next cycle:
                // STARVE_LIMIT denials, then the grant.
                if (ld_denied && (starve_cnt >= LIMIT_M1)) begin
                    state_next = S_FORCE;
                end
            end
            S_FORCE: begin
                if (!iLdValid || ends_ownership) begin
                    state_next = S_ALU;
                end
            end
            default: begin
                state_next = S_ALU;
            end
        endcase
    end

    // State register.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= S_ALU;
        end else begin
            state <= state_next;
        end
    end

    // Starvation counter: consecutive loader cycles lost to the ALU, saturating.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            starve_cnt <= '0;
        end else if (ld_xfer || !iLdValid) begin
            starve_cnt <= '0;
        end else if (ld_denied && (starve_cnt != LIMIT)) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    // Registered RAM write port; address/data hold when nothing is granted.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            oWriteEnable  <= 1'b0;
            oWriteAddress <= '0;
            oDataIn       <= '0;
        end else if (alu_grant) begin
            oWriteEnable  <= 1'b1;
            oWriteAddress <= iAluAddress;
            oDataIn       <= iAluData;
        end else if (ld_xfer) begin
            oWriteEnable  <= 1'b1;
            oWriteAddress <= iLdAddress;
            oDataIn       <= iLdData;
        end else begin
            oWriteEnable  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mini_alu_ram_arbiter.sv
// tb/tb_mini_alu_ram_arbiter.sv - directed scoreboard bench for mini_alu_ram_arbiter

module tb_mini_alu_ram_arbiter;

    logic        Clock;
    logic        Reset;
    logic        iAluWriteEnable;
    logic [7:0]  iAluAddress;
    logic [15:0] iAluData;
    logic        oAluStall;
    logic        iLdValid;
    logic [7:0]  iLdAddress;
    logic [15:0] iLdData;
    logic        iLdLast;
    logic        oLdReady;
    logic        oWriteEnable;
    logic [7:0]  oWriteAddress;
    logic [15:0] oDataIn;

    typedef struct packed {
        logic        we;
        logic [7:0]  addr;
        logic [15:0] data;
    } wr_t;

    wr_t         exp_q[$];
    logic [7:0]  hold_a;
    logic [15:0] hold_d;
    int          checks;
    int          errors;

    mini_alu_ram_arbiter #(
        .DATA_WIDTH(16),
        .ADDR_WIDTH(8),
        .STARVE_LIMIT(4)
    ) dut (
        .Clock(Clock),
        .Reset(Reset),
        .iAluWriteEnable(iAluWriteEnable),
        .iAluAddress(iAluAddress),
        .iAluData(iAluData),
        .oAluStall(oAluStall),
        .iLdValid(iLdValid),
        .iLdAddress(iLdAddress),
        .iLdData(iLdData),
        .iLdLast(iLdLast),
        .oLdReady(oLdReady),
        .oWriteEnable(oWriteEnable),
        .oWriteAddress(oWriteAddress),
        .oDataIn(oDataIn)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // g: 0 = no write granted, 1 = ALU granted, 2 = loader granted.
    task automatic step(input string tag,
                        input logic awe, input logic [7:0] aa, input logic [15:0] ad,
                        input logic lv, input logic [7:0] la, input logic [15:0] ldd,
                        input logic ll, input int g, input logic xstall);
        wr_t e;
        iAluWriteEnable = awe;
        iAluAddress     = aa;
        iAluData        = ad;
        iLdValid        = lv;
        iLdAddress      = la;
        iLdData         = ldd;
        iLdLast         = ll;
        #3;
        chk({tag, ".ready"}, 32'(oLdReady), 32'(g == 2));
        chk({tag, ".stall"}, 32'(oAluStall), 32'(xstall));
        if (g == 1) begin
            hold_a = aa;
            hold_d = ad;
            e.we   = 1'b1;
        end else if (g == 2) begin
            hold_a = la;
            hold_d = ldd;
            e.we   = 1'b1;
        end else begin
            e.we   = 1'b0;
        end
        e.addr = hold_a;
        e.data = hold_d;
        exp_q.push_back(e);
        @(posedge Clock);
        #1;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s.queue observed=empty expected=entry", tag);
        end else begin
            e = exp_q.pop_front();
            chk({tag, ".we"}, 32'(oWriteEnable), 32'(e.we));
            chk({tag, ".addr"}, 32'(oWriteAddress), 32'(e.addr));
            chk({tag, ".data"}, 32'(oDataIn), 32'(e.data));
        end
    endtask

    task automatic starve(input string tag, input logic [7:0] la, input logic [15:0] ldd, input logic ll);
        for (int i = 0; i < 4; i++) begin
            step(tag, 1'b1, 8'(8'h20 + i), 16'(16'hA000 + i), 1'b1, la, ldd, ll, 1, 1'b0);
        end
    endtask

    initial begin
        checks          = 0;
        errors          = 0;
        hold_a          = 8'h00;
        hold_d          = 16'h0000;
        Reset           = 1'b1;
        iAluWriteEnable = 1'b1;
        iAluAddress     = 8'h77;
        iAluData        = 16'h7777;
        iLdValid        = 1'b1;
        iLdAddress      = 8'h66;
        iLdData         = 16'h6666;
        iLdLast         = 1'b0;

        // Reset: handshake outputs forced low, write port cleared.
        #1;
        chk("rst.ready", 32'(oLdReady), 32'd0);
        chk("rst.stall", 32'(oAluStall), 32'd0);
        @(posedge Clock);
        #1;
        @(posedge Clock);
        #1;
        chk("rst.we", 32'(oWriteEnable), 32'd0);
        chk("rst.addr", 32'(oWriteAddress), 32'd0);
        chk("rst.data", 32'(oDataIn), 32'd0);
        Reset = 1'b0;

        step("idle", 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 16'h0000, 1'b0, 0, 1'b0);
        step("alu_only", 1'b1, 8'h05, 16'h1234, 1'b0, 8'h00, 16'h0000, 1'b0, 1, 1'b0);
        step("ld_only", 1'b0, 8'h00, 16'h0000, 1'b1, 8'h10, 16'hBEEF, 1'b0, 2, 1'b0);
        step("idle2", 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 16'h0000, 1'b0, 0, 1'b0);

        // Continuous contention: 4 ALU writes, forced loader word, repeat.
        starve("cont1", 8'h30, 16'hC0DE, 1'b0);
        step("cont1.force", 1'b1, 8'h24, 16'hA004, 1'b1, 8'h30, 16'hC0DE, 1'b0, 2, 1'b1);
        // Same address on both sides: loser retries until forced.
        for (int i = 0; i < 4; i++) begin
            step("same", 1'b1, 8'h40, 16'(16'hB000 + i), 1'b1, 8'h40, 16'hD00D, 1'b0, 1, 1'b0);
        end
        step("same.force", 1'b1, 8'h40, 16'hB004, 1'b1, 8'h40, 16'hD00D, 1'b0, 2, 1'b1);
        step("same.resume", 1'b1, 8'h40, 16'hB004, 1'b0, 8'h00, 16'h0000, 1'b0, 1, 1'b0);

        // Three-word loader burst against a busy ALU.
`ifdef MINI_ALU_ARB_BURST_EN
        starve("bst", 8'h50, 16'h0001, 1'b0);
        step("bst.w1", 1'b1, 8'h24, 16'hA004, 1'b1, 8'h50, 16'h0001, 1'b0, 2, 1'b1);
        step("bst.w2", 1'b1, 8'h24, 16'hA004, 1'b1, 8'h51, 16'h0002, 1'b0, 2, 1'b1);
        step("bst.w3", 1'b1, 8'h24, 16'hA004, 1'b1, 8'h52, 16'h0003, 1'b1, 2, 1'b1);
`else
        starve("bst1", 8'h50, 16'h0001, 1'b0);
        step("bst.w1", 1'b1, 8'h24, 16'hA004, 1'b1, 8'h50, 16'h0001, 1'b0, 2, 1'b1);
        starve("bst2", 8'h51, 16'h0002, 1'b0);
        step("bst.w2", 1'b1, 8'h24, 16'hA004, 1'b1, 8'h51, 16'h0002, 1'b0, 2, 1'b1);
        starve("bst3", 8'h52, 16'h0003, 1'b1);
        step("bst.w3", 1'b1, 8'h24, 16'hA004, 1'b1, 8'h52, 16'h0003, 1'b1, 2, 1'b1);
`endif
        step("bst.resume", 1'b1, 8'h60, 16'h6000, 1'b0, 8'h00, 16'h0000, 1'b0, 1, 1'b0);

        // Loader withdraws while it owns the port: ALU stalled, nothing written.
        starve("drop", 8'h70, 16'h7070, 1'b0);
        step("drop.force", 1'b1, 8'h25, 16'hA005, 1'b0, 8'h70, 16'h7070, 1'b0, 0, 1'b1);
        step("drop.resume", 1'b1, 8'h26, 16'hA006, 1'b0, 8'h00, 16'h0000, 1'b0, 1, 1'b0);

        // Reset while the loader owns the port: no partial write, counter cleared.
        starve("rstf", 8'h80, 16'h8080, 1'b0);
        Reset = 1'b1;
        #3;
        chk("rstf.ready", 32'(oLdReady), 32'd0);
        chk("rstf.stall", 32'(oAluStall), 32'd0);
        @(posedge Clock);
        #1;
        chk("rstf.we", 32'(oWriteEnable), 32'd0);
        chk("rstf.addr", 32'(oWriteAddress), 32'd0);
        chk("rstf.data", 32'(oDataIn), 32'd0);
        Reset  = 1'b0;
        hold_a = 8'h00;
        hold_d = 16'h0000;
        starve("post", 8'h80, 16'h8080, 1'b0);
        step("post.force", 1'b1, 8'h24, 16'hA004, 1'b1, 8'h80, 16'h8080, 1'b0, 2, 1'b1);
        step("post.idle", 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 16'h0000, 1'b0, 0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
